// File: rtl/u111_lb_target.sv
`default_nettype none
// ============================================================================
//  Module   : u111_lb_target
//  Purpose  : 68040 local-bus target with three R/W registers and an ID word,
//             used as the bring-up partner for the U111 bus-sizing initiator.
//  Revision : 1.0  initial release
// ============================================================================
module u111_lb_target #(
  parameter bit          PORT16 = 1'b0,
  parameter int unsigned WAIT   = 2,
  parameter logic [31:0] ID     = 32'h4150_4349
) (
  input  logic        CLK40,
  input  logic        RESET,
  input  logic        TSn,
  input  logic        SEL,
  input  logic [7:0]  A,
  input  logic [1:0]  SIZ,
  input  logic        RnW,
  input  logic [31:0] D_IN,
  output logic [31:0] D_OUT,
  output logic        D_OE,
  output logic        TACKn,
  output logic        TEAn,
  output logic        PORTSIZE,
  output logic        BUSY
);

  localparam logic [1:0] SIZ_LONG = 2'b00;
  localparam logic [1:0] SIZ_BYTE = 2'b01;
  localparam logic [1:0] SIZ_WORD = 2'b10;
  localparam logic [1:0] SIZ_LINE = 2'b11;
  localparam logic [2:0] WAIT_CNT = 3'(WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t      state_q;
  logic [1:0]  alo_q;
  logic [1:0]  siz_q;
  logic        rnw_q;
  logic        err_q;
  logic [2:0]  cnt_q;
  logic [1:0]  idx_q;
  logic [1:0]  beat_q;
  logic [31:0] regs_q [3];
  logic [31:0] dout_q;
  logic        oe_q;
  logic        tack_q;
  logic        tea_q;

  logic        start_err_d;
  logic [3:0]  wmask_d;
  logic [31:0] wdata_d;
  logic [1:0]  idx_nxt_d;
  logic [31:0] rd_cur_d;
  logic [31:0] rd_nxt_d;

  function automatic logic [31:0] pick(input logic [1:0] idx, input logic [31:0] r0,
                                       input logic [31:0] r1, input logic [31:0] r2);
    case (idx)
      2'd0:    return r0;
      2'd1:    return r1;
      2'd2:    return r2;
      default: return ID;
    endcase
  endfunction

  // A 16-bit port always returns the addressed half on the upper lanes.
  function automatic logic [31:0] fmt(input logic [31:0] w, input logic a1);
    if (PORT16) return a1 ? {w[15:0], 16'h0000} : {w[31:16], 16'h0000};
    return w;
  endfunction

  always_comb begin
    start_err_d = (A[7:4] != 4'h0);
    case (SIZ)
      SIZ_WORD: if (A[0])                     start_err_d = 1'b1;
      SIZ_LONG: if (A[1:0] != 2'b00)          start_err_d = 1'b1;
      SIZ_LINE: if (PORT16 || A[1:0] != 2'b00) start_err_d = 1'b1;
      default: ;
    endcase
  end

  // Byte-enable mask is indexed with bit 3 = register bits [31:24].
  always_comb begin
    wdata_d = D_IN;
    wmask_d = 4'b1111;
    if (PORT16) begin
      wdata_d = alo_q[1] ? {16'h0000, D_IN[31:16]} : {D_IN[31:16], 16'h0000};
      if (siz_q == SIZ_BYTE) wmask_d = 4'b1000 >> alo_q;
      else                   wmask_d = alo_q[1] ? 4'b0011 : 4'b1100;
    end else begin
      case (siz_q)
        SIZ_BYTE: wmask_d = 4'b1000 >> alo_q;
        SIZ_WORD: wmask_d = alo_q[1] ? 4'b0011 : 4'b1100;
        default:  wmask_d = 4'b1111;
      endcase
    end
  end

  always_comb begin
    idx_nxt_d = idx_q + 2'd1;
    rd_cur_d  = fmt(pick(idx_q,     regs_q[0], regs_q[1], regs_q[2]), alo_q[1]);
    rd_nxt_d  = fmt(pick(idx_nxt_d, regs_q[0], regs_q[1], regs_q[2]), alo_q[1]);
  end

  always_ff @(posedge CLK40) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      alo_q   <= 2'b00;
      siz_q   <= SIZ_LONG;
      rnw_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 3'd0;
      idx_q   <= 2'd0;
      beat_q  <= 2'd0;
      dout_q  <= 32'h0;
      oe_q    <= 1'b0;
      tack_q  <= 1'b1;
      tea_q   <= 1'b1;
      for (int r = 0; r < 3; r++) regs_q[r] <= 32'h0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!TSn && SEL) begin
            alo_q   <= A[1:0];
            idx_q   <= A[3:2];
            siz_q   <= SIZ;
            rnw_q   <= RnW;
            err_q   <= start_err_d;
            cnt_q   <= WAIT_CNT;
            beat_q  <= (SIZ == SIZ_LINE) ? 2'd3 : 2'd0;
            state_q <= ST_WAIT;
          end
        end
        // The first WAIT cycle doubles as the decode cycle, so errors and
        // zero-wait acks both respond one clock after the start edge.
        ST_WAIT: begin
          if (err_q) begin
            state_q <= ST_ERR;
            tea_q   <= 1'b0;
          end else if (cnt_q == 3'd0) begin
            state_q <= ST_ACK;
            tack_q  <= 1'b0;
            oe_q    <= rnw_q;
            dout_q  <= rd_cur_d;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_ACK: begin
          if (!rnw_q) begin
            for (int r = 0; r < 3; r++) begin
              if (idx_q == 2'(r)) begin
                for (int b = 0; b < 4; b++) begin
                  if (wmask_d[b]) regs_q[r][8*b +: 8] <= wdata_d[8*b +: 8];
                end
              end
            end
          end
          if (beat_q != 2'd0) begin
            beat_q <= beat_q - 2'd1;
            idx_q  <= idx_nxt_d;
            dout_q <= rd_nxt_d;
          end else begin
            state_q <= ST_IDLE;
            tack_q  <= 1'b1;
            oe_q    <= 1'b0;
          end
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
          tea_q   <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign D_OUT    = dout_q;
  assign D_OE     = oe_q;
  assign TACKn    = tack_q;
  assign TEAn     = tea_q;
  assign PORTSIZE = PORT16;
  assign BUSY     = (state_q != ST_IDLE);

endmodule
`default_nettype wire
